// File: rtl/video_source_select_if.sv
// Pixel-stream bundle for video_source_select: N_CH ready/valid inputs and one ready/valid output.
// master drives the sources and the downstream ready; slave is the selector itself.
interface video_source_select_if #(
  parameter int unsigned N_CH  = 5,
  parameter int unsigned WIDTH = 8
);
  logic [N_CH*WIDTH-1:0] in_pixel;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_pixel;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_pixel, out_valid
  );

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_pixel, out_valid
  );
endinterface

// File: rtl/video_source_select.sv
// Frame-aligned N-channel pixel-stream selector with a one-deep registered output stage.
// Define VIDEO_SELECT_DRAIN_EN to drain (accept and discard) beats on non-selected channels.
module video_source_select #(
  parameter int unsigned N_CH    = 5,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned N_PIXEL = 480000,
  parameter int unsigned CNT_W   = 19,
  parameter int unsigned SEL_W   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  video_source_select_if.slave  bus,
  output logic [SEL_W-1:0]      active_sel,
  output logic [CNT_W-1:0]      pixel_count,
  output logic                  frame_done,
  output logic                  switch_pending
);

  localparam logic [SEL_W:0]   NumCh     = (SEL_W+1)'(N_CH);
  localparam logic [CNT_W-1:0] LastPixel = CNT_W'(N_PIXEL - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] req_sel_q, req_sel_d;
  logic [SEL_W-1:0] active_sel_q, active_sel_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_pixel_q, out_pixel_d;
  logic             out_valid_q, out_valid_d;
  logic             switch_pending_q;
  logic [N_CH-1:0]  ready_c;
  logic [WIDTH-1:0] ch_pixel [N_CH];
  logic             in_xfer, out_xfer;

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_pixel[k] = bus.in_pixel[k*WIDTH +: WIDTH];
  end

  // Out-of-range requests are ignored so the last legal request stands.
  assign req_sel_d = ({1'b0, sel} < NumCh) ? sel : req_sel_q;

  always_comb begin
    ready_c = '0;
`ifdef VIDEO_SELECT_DRAIN_EN
    ready_c = '1;
    if (state_q == StIdle) begin
      ready_c[req_sel_d] = 1'b0;
    end else begin
      ready_c[active_sel_q] = 1'b0;
    end
`endif
    if (state_q == StStream) begin
      ready_c[active_sel_q] = ~out_valid_q | bus.out_ready;
    end
    if (reset) begin
      ready_c = '0;
    end
  end

  assign in_xfer  = (state_q == StStream) & bus.in_valid[active_sel_q] & ready_c[active_sel_q];
  assign out_xfer = out_valid_q & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    count_d      = count_q;
    out_pixel_d  = out_pixel_q;
    out_valid_d  = out_valid_q;
    frame_done   = 1'b0;
    if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        // Take the request being registered this edge so a sel held through reset applies at once.
        active_sel_d = req_sel_d;
        state_d      = StStream;
      end
      StStream: begin
        if (in_xfer) begin
          out_pixel_d = ch_pixel[active_sel_q];
          out_valid_d = 1'b1;
          if (count_q == LastPixel) begin
            count_d = '0;
            state_d = StFlush;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      StFlush: begin
        if (out_xfer) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      req_sel_q        <= '0;
      active_sel_q     <= '0;
      count_q          <= '0;
      out_pixel_q      <= '0;
      out_valid_q      <= 1'b0;
      switch_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_sel_q        <= req_sel_d;
      active_sel_q     <= active_sel_d;
      count_q          <= count_d;
      out_pixel_q      <= out_pixel_d;
      out_valid_q      <= out_valid_d;
      switch_pending_q <= (req_sel_q != active_sel_q);
    end
  end

  assign bus.in_ready    = ready_c;
  assign bus.out_pixel   = out_pixel_q;
  assign bus.out_valid   = out_valid_q;
  assign active_sel      = active_sel_q;
  assign pixel_count     = count_q;
  assign switch_pending  = switch_pending_q;

endmodule

// File: tb/tb_video_source_select.sv
// Scoreboard bench for video_source_select: accepted beats of the expected channel are queued
// and compared in order against output transfers; frame gaps, stalls and reset are also checked.
module tb_video_source_select;
  localparam int unsigned N_CH    = 5;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned N_PIXEL = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SEL_W   = 3;
`ifdef VIDEO_SELECT_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] active_sel;
  logic [CNT_W-1:0] pixel_count;
  logic             frame_done;
  logic             switch_pending;

  video_source_select_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

  video_source_select #(
    .N_CH(N_CH), .WIDTH(WIDTH), .N_PIXEL(N_PIXEL), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clock(clock), .reset(reset), .sel(sel), .bus(bus), .active_sel(active_sel),
    .pixel_count(pixel_count), .frame_done(frame_done), .switch_pending(switch_pending)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus state
  logic [N_CH-1:0] valid_mask = '0;
  int              out_mode   = 0;
  int              base [N_CH];
  int              idx  [N_CH];
  int              cyc        = 0;
  logic [N_CH-1:0] acc_q      = '0;
  bit              drain_test = 1'b0;

  // Model / scoreboard state
  logic [WIDTH-1:0] sb [$];
  logic [SEL_W-1:0] exp_active = '0;
  logic [SEL_W-1:0] req_model  = '0;
  bit               in_frame   = 1'b0;
  int               in_cnt     = 0;
  int               out_cnt    = 0;
  int               frames     = 0;
  int               idle_chk   = 0;
  bit               latency_pend = 1'b0;
  bit               stall_prev   = 1'b0;
  logic [WIDTH-1:0] stall_pix    = '0;

  always @(posedge clock) begin
    logic [N_CH*WIDTH-1:0] pix;
    #1;
    for (int k = 0; k < N_CH; k++) begin
      if (acc_q[k]) idx[k]++;
      pix[k*WIDTH +: WIDTH] = WIDTH'(base[k] + idx[k]);
    end
    bus.in_pixel  = pix;
    bus.in_valid  = valid_mask;
    cyc++;
    bus.out_ready = (out_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
  end

  always @(negedge clock) begin : mon
    logic [N_CH-1:0] acc, mask;
    logic            out_xfer;
    if (reset) begin
      acc_q = '0;
    end else begin
      acc = bus.in_valid & bus.in_ready;
      if (idle_chk == 2) begin
        check_eq("idle_one", bus.in_ready[exp_active], 1);
        check_eq("active_sel", active_sel, exp_active);
        idle_chk = 0;
      end else if (idle_chk == 1) begin
        exp_active = (sel < N_CH) ? sel : req_model;
        check_eq("idle_gap", bus.in_ready[exp_active], 0);
        in_frame = 1'b1;
        in_cnt   = 0;
        idle_chk = 2;
      end
      mask = '0;
      mask[exp_active] = 1'b1;
      if (latency_pend) check_eq("latency", bus.out_valid, 1);
      if (stall_prev) begin
        check_eq("stall_valid", bus.out_valid, 1);
        check_eq("stall_hold", bus.out_pixel, stall_pix);
      end
      if (bus.out_valid && !bus.out_ready) check_eq("stall_ready", bus.in_ready[exp_active], 0);
      check_eq("bp_other", bus.in_ready & ~mask & ~{N_CH{DRAIN}}, 0);
      if (drain_test) check_eq("drain_rdy3", bus.in_ready[3], DRAIN);
      latency_pend = 1'b0;
      if (in_frame && acc[exp_active]) begin
        check_eq("pixel_count", pixel_count, in_cnt);
        sb.push_back(bus.in_pixel[exp_active*WIDTH +: WIDTH]);
        latency_pend = 1'b1;
        in_cnt++;
        if (in_cnt == N_PIXEL) begin
          in_cnt   = 0;
          in_frame = 1'b0;
        end
      end
      out_xfer = bus.out_valid & bus.out_ready;
      check_eq("frame_done", frame_done, out_xfer && (out_cnt == N_PIXEL - 1));
      if (out_xfer) begin
        check_eq("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) check_eq("out_pixel", bus.out_pixel, sb.pop_front());
        out_cnt++;
        if (out_cnt == N_PIXEL) begin
          out_cnt = 0;
          frames++;
          check_eq("frame_empty", sb.size(), 0);
          idle_chk = 1;
        end
      end
      stall_prev = bus.out_valid & ~bus.out_ready;
      stall_pix  = bus.out_pixel;
      acc_q      = acc;
      if (sel < N_CH) req_model = sel;
    end
  end

  task automatic release_reset();
    @(negedge clock);
    #1;
    reset        = 1'b0;
    exp_active   = (sel < N_CH) ? sel : '0;
    req_model    = exp_active;
    in_frame     = 1'b1;
    in_cnt       = 0;
    out_cnt      = 0;
    idle_chk     = 2;
    latency_pend = 1'b0;
    stall_prev   = 1'b0;
    sb.delete();
  endtask

  task automatic wait_frames(input int n);
    int target = frames + n;
    int t = 0;
    while (frames < target && t < 400) begin
      @(posedge clock);
      #1;
      t++;
    end
    check_eq("wait_frames", frames >= target, 1);
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (!(in_frame && in_cnt >= n) && t < 400) begin
      @(posedge clock);
      #1;
      t++;
    end
    check_eq("wait_beats", in_frame && in_cnt >= n, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, bus.out_valid, 0);
    check_eq({tag, "_out_pixel"}, bus.out_pixel, 0);
    check_eq({tag, "_count"}, pixel_count, 0);
    check_eq({tag, "_active"}, active_sel, 0);
    check_eq({tag, "_in_ready"}, bus.in_ready, 0);
    check_eq({tag, "_pending"}, switch_pending, 0);
    check_eq({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    for (int k = 0; k < N_CH; k++) begin
      base[k] = 16 + k * 48;
      idx[k]  = 0;
    end
    base[2] = 0;
    reset   = 1'b1;
    sel     = 3'd2;
    repeat (2) @(negedge clock);
    #1;
    check_reset_outputs("rst0");

    // Reset recovery: ch2 frame 0x00..0x0F
    valid_mask = 5'b00100;
    release_reset();
    wait_frames(1);

    // Mid-frame switch 2 -> 4
    base[2]    = 100;
    idx[2]     = 0;
    valid_mask = 5'b10100;
    wait_beats(5);
    sel = 3'd4;
    repeat (3) @(posedge clock);
    #1;
    check_eq("switch_pending_set", switch_pending, 1);
    check_eq("active_hold", active_sel, 2);
    wait_frames(1);
    wait_beats(2);
    check_eq("switch_pending_clr", switch_pending, 0);
    wait_frames(1);

    // Backpressure on ch1
    sel        = 3'd1;
    valid_mask = 5'b00010;
    out_mode   = 1;
    wait_frames(1);

    // Invalid select mid-stream
    out_mode = 0;
    wait_beats(4);
    sel = 3'd7;
    repeat (3) @(posedge clock);
    #1;
    check_eq("invalid_pending", switch_pending, 0);
    check_eq("invalid_active", active_sel, 1);
    wait_frames(1);

    // Reset mid-frame at pixel_count 9
    wait_beats(9);
    check_eq("pre_reset_count", pixel_count, 9);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");

    // Drain behaviour: ch0 active, ch3 always valid
    repeat (2) @(posedge clock);
    sel        = 3'd0;
    base[0]    = 200;
    valid_mask = 5'b01001;
    drain_test = 1'b1;
    release_reset();
    wait_frames(2);
    drain_test = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
